// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous data RAM between the CPU data port
// (single read/write accesses) and the Game-of-Life video reader (fixed
// length read bursts). The CPU normally has priority; a starvation counter
// forces the video reader to win after MAX_WAIT consecutive lost
// arbitrations. Once a burst starts it runs to completion without
// preemption.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   CPU access request, held until cpu_gnt
//   cpu_gnt, cpu_stall      same-cycle grant, and cpu_req & ~cpu_gnt
//   cpu_rvalid, cpu_rdata   read data, one cycle after a granted read
//   vid_req/addr/len        burst request (len = beats - 1), held until vid_gnt
//   vid_gnt                 single-cycle burst accept pulse
//   vid_rvalid/rdata/last   one beat per cycle, last marks the final beat
//   mem_en/we/addr/wdata    RAM command, one access per cycle
//   mem_rdata               RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int LENW     = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [DW-1:0]   cpu_wdata,
   output logic            cpu_gnt,
   output logic            cpu_stall,
   output logic            cpu_rvalid,
   output logic [DW-1:0]   cpu_rdata,
   input  logic            vid_req,
   input  logic [AW-1:0]   vid_addr,
   input  logic [LENW-1:0] vid_len,
   output logic            vid_gnt,
   output logic            vid_rvalid,
   output logic [DW-1:0]   vid_rdata,
   output logic            vid_last,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int SW = $clog2(MAX_WAIT + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
   localparam logic [AW-1:0] BEAT_BYTES = AW'(4);
   localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);

   logic [0:0]      state_q, state_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [AW-1:0]   next_addr_q, next_addr_d;
   logic [LENW-1:0] remaining_q, remaining_d;
   logic            cpu_rvalid_q, cpu_rvalid_d;
   logic            vid_rvalid_q, vid_rvalid_d;
   logic            vid_last_q, vid_last_d;

   // Ungated command/grant values; reset masks them at the ports.
   logic            vid_win, cpu_win;
   logic            cpu_gnt_c, vid_gnt_c;
   logic            en_c, we_c;
   logic [AW-1:0]   addr_c;
   logic [DW-1:0]   wdata_c;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      next_addr_d  = next_addr_q;
      remaining_d  = remaining_q;
      cpu_rvalid_d = 1'b0;
      vid_rvalid_d = 1'b0;
      vid_last_d   = 1'b0;
      vid_win      = 1'b0;
      cpu_win      = 1'b0;
      cpu_gnt_c    = 1'b0;
      vid_gnt_c    = 1'b0;
      en_c         = 1'b0;
      we_c         = 1'b0;
      addr_c       = '0;
      wdata_c      = '0;

      case (state_q)
         ST_IDLE: begin
            vid_win = vid_req & (~cpu_req | (starve_cnt_q == STARVE_MAX));
            cpu_win = cpu_req & ~vid_win;

            if (vid_win) begin
               // Beat 0 goes out in the grant cycle; the rest come from BURST.
               vid_gnt_c    = 1'b1;
               en_c         = 1'b1;
               addr_c       = vid_addr;
               next_addr_d  = vid_addr + BEAT_BYTES;
               remaining_d  = vid_len;
               vid_rvalid_d = 1'b1;
               vid_last_d   = (vid_len == '0);
               starve_cnt_d = '0;
               if (vid_len != '0) begin
                  state_d = ST_BURST;
               end
            end else begin
               if (cpu_win) begin
                  cpu_gnt_c    = 1'b1;
                  en_c         = 1'b1;
                  we_c         = cpu_we;
                  addr_c       = cpu_addr;
                  wdata_c      = cpu_wdata;
                  cpu_rvalid_d = ~cpu_we;
               end
               // Here a pending vid_req has necessarily just lost.
               if (vid_req) begin
                  if (starve_cnt_q != STARVE_MAX) begin
                     starve_cnt_d = starve_cnt_q + 1'b1;
                  end
               end else begin
                  starve_cnt_d = '0;
               end
            end
         end

         default: begin
            // BURST: one beat per cycle, CPU locked out, vid_req ignored,
            // starvation counter held.
            en_c         = 1'b1;
            addr_c       = next_addr_q;
            next_addr_d  = next_addr_q + BEAT_BYTES;
            remaining_d  = remaining_q - 1'b1;
            vid_rvalid_d = 1'b1;
            if (remaining_q == LEN_ONE) begin
               vid_last_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= '0;
         next_addr_q  <= '0;
         remaining_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         vid_rvalid_q <= 1'b0;
         vid_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         next_addr_q  <= next_addr_d;
         remaining_q  <= remaining_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vid_rvalid_q <= vid_rvalid_d;
         vid_last_q   <= vid_last_d;
      end
   end

   // Grants and the RAM command are forced idle for as long as reset is low,
   // so an abandoned burst issues nothing even before the next clock edge.
   assign cpu_gnt   = cpu_gnt_c & reset;
   assign vid_gnt   = vid_gnt_c & reset;
   assign mem_en    = en_c & reset;
   assign mem_we    = we_c & reset;
   assign mem_addr  = addr_c & {AW{reset}};
   assign mem_wdata = wdata_c & {DW{reset}};

   assign cpu_stall  = cpu_req & ~cpu_gnt;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = mem_rdata;
   assign vid_rvalid = vid_rvalid_q;
   assign vid_rdata  = mem_rdata;
   assign vid_last   = vid_last_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives directed and random CPU/video traffic into mem_arbiter backed by a
// behavioural RAM. A transaction-level reference (occupancy count, loss
// count, shadow memory) predicts grants and the RAM command every cycle and
// queues expected read data; a separate monitor pops the queues whenever the
// DUT presents rvalid.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;
   localparam int LENW     = 4;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          due;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            cpu_req, cpu_we;
   logic [AW-1:0]   cpu_addr;
   logic [DW-1:0]   cpu_wdata;
   logic            cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DW-1:0]   cpu_rdata;
   logic            vid_req;
   logic [AW-1:0]   vid_addr;
   logic [LENW-1:0] vid_len;
   logic            vid_gnt, vid_rvalid, vid_last;
   logic [DW-1:0]   vid_rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t cq[$];
   exp_t vq[$];

   logic cpu_gnt_s = 1'b0;
   logic vid_gnt_s = 1'b0;

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LENW(LENW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_stall (cpu_stall),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_len   (vid_len),
      .vid_gnt   (vid_gnt),
      .vid_rvalid(vid_rvalid),
      .vid_rdata (vid_rdata),
      .vid_last  (vid_last),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Initial RAM contents; word 0x100 holds a recognisable pattern.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a[31:2] == 30'h40) return 32'hDEAD_BEEF;
      return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
   endfunction

   // ---------------- behavioural RAM seen by the DUT ----------------
   logic [31:0] ram [logic [29:0]];
   logic        env_en, env_we;
   logic [31:0] env_addr, env_wdata;

   always @(negedge clk) begin
      env_en    = mem_en;
      env_we    = mem_we;
      env_addr  = mem_addr;
      env_wdata = mem_wdata;
   end

   always @(posedge clk) begin
      if (env_en) begin
         if (env_we) ram[env_addr[31:2]] = env_wdata;
         else mem_rdata <= ram.exists(env_addr[31:2]) ? ram[env_addr[31:2]] : init_word(env_addr);
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [logic [29:0]];
   int          busy  = 0;   // burst beats still to issue after this one
   int          waits = 0;   // consecutive lost arbitrations of video
   logic [31:0] burst_base, beat_idx;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
   endfunction

   always @(negedge clk) begin
      logic        e_en, e_we, e_cg, e_vg;
      logic [31:0] e_addr, e_wdata;
      exp_t        item;
      cpu_gnt_s = cpu_gnt;
      vid_gnt_s = vid_gnt;
      if (!reset) begin
         busy  = 0;
         waits = 0;
         check1("rst_cpu_gnt", cpu_gnt, 1'b0);
         check1("rst_vid_gnt", vid_gnt, 1'b0);
         check1("rst_mem_en", mem_en, 1'b0);
      end else begin
         e_en = 1'b0; e_we = 1'b0; e_cg = 1'b0; e_vg = 1'b0;
         e_addr = '0; e_wdata = '0;
         if (busy > 0) begin
            e_en      = 1'b1;
            e_addr    = burst_base + (beat_idx << 2);
            item.data = ref_rd(e_addr);
            item.last = (busy == 1);
            item.due  = cyc + 1;
            vq.push_back(item);
            busy--;
            beat_idx++;
         end else if (vid_req && (!cpu_req || waits == MAX_WAIT)) begin
            e_vg       = 1'b1;
            e_en       = 1'b1;
            e_addr     = vid_addr;
            item.data  = ref_rd(e_addr);
            item.last  = (vid_len == 0);
            item.due   = cyc + 1;
            vq.push_back(item);
            busy       = int'(vid_len);
            burst_base = vid_addr;
            beat_idx   = 1;
            waits      = 0;
         end else begin
            if (cpu_req) begin
               e_cg    = 1'b1;
               e_en    = 1'b1;
               e_we    = cpu_we;
               e_addr  = cpu_addr;
               e_wdata = cpu_wdata;
               if (cpu_we) ref_mem[cpu_addr[31:2]] = cpu_wdata;
               else begin
                  item.data = ref_rd(cpu_addr);
                  item.last = 1'b0;
                  item.due  = cyc + 1;
                  cq.push_back(item);
               end
            end
            waits = vid_req ? ((waits < MAX_WAIT) ? waits + 1 : waits) : 0;
         end
         check1("cpu_gnt", cpu_gnt, e_cg);
         check1("vid_gnt", vid_gnt, e_vg);
         check1("cpu_stall", cpu_stall, cpu_req & ~e_cg);
         check1("mem_en", mem_en, e_en);
         if (e_en) begin
            check32("mem_addr", mem_addr, e_addr);
            check1("mem_we", mem_we, e_we);
            if (e_we) check32("mem_wdata", mem_wdata, e_wdata);
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         cq.delete();
         vq.delete();
      end else begin
         if (cpu_rvalid || (cq.size() > 0 && cq[0].due <= cyc)) begin
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpu_rvalid_unexpected: actual=1 expected=0 t=%0t", $time);
            end else begin
               e = cq.pop_front();
               check1("cpu_rvalid", cpu_rvalid, 1'b1);
               check32("cpu_rdata", cpu_rdata, e.data);
            end
         end
         if (vid_rvalid || (vq.size() > 0 && vq[0].due <= cyc)) begin
            if (vq.size() == 0) begin
               checks++; errors++;
               $display("FAIL vid_rvalid_unexpected: actual=1 expected=0 t=%0t", $time);
            end else begin
               e = vq.pop_front();
               check1("vid_rvalid", vid_rvalid, 1'b1);
               check32("vid_rdata", vid_rdata, e.data);
               check1("vid_last", vid_last, e.last);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [31:0] wrap_addr [4];
   logic [1:0]  starve_pat [7];

   initial begin
      int cpu_age, vid_age;
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_addr = '0; vid_len = '0;
      mem_rdata = '0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check1("reset_cpu_rvalid", cpu_rvalid, 1'b0);
      check1("reset_vid_rvalid", vid_rvalid, 1'b0);
      check1("reset_vid_last", vid_last, 1'b0);
      check1("reset_mem_en", mem_en, 1'b0);

      // CPU read of the preloaded word.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
      @(negedge clk);
      check1("rd_gnt", cpu_gnt, 1'b1);
      check32("rd_mem_addr", mem_addr, 32'h100);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      check1("rd_rvalid", cpu_rvalid, 1'b1);
      check32("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // CPU write.
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h104; cpu_wdata = 32'h5;
      @(negedge clk);
      check1("wr_mem_en", mem_en, 1'b1);
      check1("wr_mem_we", mem_we, 1'b1);
      check32("wr_mem_wdata", mem_wdata, 32'h5);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      check1("wr_no_rvalid", cpu_rvalid, 1'b0);

      // 4-beat burst, CPU arrives right after the video grant.
      step();
      vid_req = 1'b1; vid_addr = 32'h2000; vid_len = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) check1("burst_vid_gnt", vid_gnt, 1'b1);
         if (i < 4) check32("burst_addr", mem_addr, 32'h2000 + 32'(i * 4));
         check1("burst_rvalid", vid_rvalid, i >= 1);
         check1("burst_last", vid_last, i == 4);
         if (i >= 1 && i <= 3) check1("burst_cpu_stall", cpu_stall, 1'b1);
         if (i == 4) check1("burst_cpu_gnt", cpu_gnt, 1'b1);
         step();
         if (i == 0) begin
            vid_req = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h108; cpu_wdata = 32'h77;
         end
      end
      cpu_req = 1'b0;
      step();

      // Starvation: both held continuously, single-beat video bursts.
      starve_pat = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
      vid_req = 1'b1; vid_addr = 32'h40; vid_len = 4'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check32("starve_grants", 32'({cpu_gnt, vid_gnt}), 32'(starve_pat[i]));
         step();
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      step();

      // Address wrap.
      wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      vid_req = 1'b1; vid_addr = 32'hFFFF_FFF8; vid_len = 4'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check32("wrap_addr", mem_addr, wrap_addr[i]);
         step();
         vid_req = 1'b0;
      end
      repeat (2) step();

      // Reset during beat 2 of a 4-beat burst.
      vid_req = 1'b1; vid_addr = 32'h3000; vid_len = 4'd3;
      step();
      vid_req = 1'b0;
      step();
      #1 reset = 1'b0;
      #1;
      check1("midrst_mem_en", mem_en, 1'b0);
      check1("midrst_vid_rvalid", vid_rvalid, 1'b0);
      check1("midrst_cpu_gnt", cpu_gnt, 1'b0);
      repeat (2) step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check1("postrst_mem_en", mem_en, 1'b0);
         step();
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
      @(negedge clk);
      check1("postrst_idle_gnt", cpu_gnt, 1'b1);
      step();
      cpu_req = 1'b0;

      // Random traffic.
      cpu_age = 0; vid_age = 0;
      for (int n = 0; n < 1500; n++) begin
         step();
         if (cpu_req && cpu_gnt_s) begin cpu_req = 1'b0; cpu_age = 0; end
         if (vid_req && vid_gnt_s) begin vid_req = 1'b0; vid_age = 0; end
         if (cpu_req) cpu_age++;
         if (vid_req) vid_age++;
         if (cpu_age > 40 || vid_age > 40) begin
            checks++; errors++;
            $display("FAIL grant_timeout: actual cpu_age=%0d vid_age=%0d expected <=40", cpu_age, vid_age);
            cpu_req = 1'b0; vid_req = 1'b0; cpu_age = 0; vid_age = 0;
         end
         if (!cpu_req && $urandom_range(0, 99) < 60) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 63)) << 2;
            cpu_wdata = $urandom;
         end
         if (!vid_req && $urandom_range(0, 99) < 15) begin
            vid_req  = 1'b1;
            vid_len  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
               0: vid_addr = 32'($urandom_range(0, 63)) << 2;
               1: vid_addr = 32'hFFFF_FFC0 + (32'($urandom_range(0, 15)) << 2);
               default: vid_addr = $urandom & 32'hFFFF_FFFC;
            endcase
         end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      repeat (25) step();
      check32("cpu_queue_drained", 32'(cq.size()), 32'd0);
      check32("vid_queue_drained", 32'(vq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
